// File: rtl/uart_apb_fifo.sv
// ----------------------------------------------------------------------------
// uart_apb_fifo -- APB3 slave console UART (8N1) with TX/RX FIFOs.
//
// Register map (byte address, [3:2] decoded):
//   0x0 DATA  W: push TX byte (full -> dropped, pslverr)   R: pop RX byte (empty -> 0)
//   0x4 STAT  R: [0]tx_full [1]tx_idle [2]rx_valid [3]rx_full [4]overrun
//               [5]frame_err [15:8]tx_count [23:16]rx_count
//             W: writing 1 to [4]/[5] clears the sticky flag
//   0x8 DIV   RW baud divisor, bit period = DIV+1 clocks
//   0xC CTRL  RW [0]tx_en [1]rx_en [2]loopback [4]ie_rx [5]ie_tx_idle
//
// Ports:
//   clock, reset           system clock, asynchronous active-low reset
//   in_psel .. in_pstrb    APB3 request (pprot, pstrb and unused paddr bits ignored)
//   in_pready/pslverr/prdata  APB3 response, zero wait states
//   uart_rx / uart_tx      serial line, idle high
//   irq                    registered level interrupt
//
// Optional build macro: UART_SIM_PRINT_EN -- echoes every accepted DATA write
// to the simulator console with $write. Leave undefined for synthesis.
// ----------------------------------------------------------------------------
module uart_apb_fifo #(
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter int          DIV_W     = 16,
  parameter int unsigned DIV_RESET = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic [31:0] in_paddr,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic        in_pslverr,
  output logic [31:0] in_prdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_FULL_CNT = (RAW+1)'(RX_DEPTH);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_DIV  = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  // Shared by both serial FSMs.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // APB decode
  // --------------------------------------------------------------------------
  logic       access, wr_acc, rd_acc;
  logic [1:0] reg_sel;

  assign access    = in_psel & in_penable;
  assign wr_acc    = access & in_pwrite;
  assign rd_acc    = access & ~in_pwrite;
  assign reg_sel   = in_paddr[3:2];
  assign in_pready = access;

  // Inputs the register map deliberately ignores.
  logic unused_ok;
  assign unused_ok = ^{in_pprot, in_pstrb, in_paddr[31:4], in_paddr[1:0], in_pwdata};

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  logic             tx_en, rx_en, loopback, ie_rx, ie_tx_idle;
  logic [DIV_W-1:0] div_q;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_en      <= 1'b1;
      rx_en      <= 1'b1;
      loopback   <= 1'b0;
      ie_rx      <= 1'b0;
      ie_tx_idle <= 1'b0;
      div_q      <= DIV_W'(DIV_RESET);
    end else if (wr_acc) begin
      if (reg_sel == A_DIV) div_q <= in_pwdata[DIV_W-1:0];
      if (reg_sel == A_CTRL) begin
        tx_en      <= in_pwdata[0];
        rx_en      <= in_pwdata[1];
        loopback   <= in_pwdata[2];
        ie_rx      <= in_pwdata[4];
        ie_tx_idle <= in_pwdata[5];
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO + transmitter
  // --------------------------------------------------------------------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TAW:0]     tx_wp, tx_rp, tx_cnt;
  logic             tx_full, tx_empty, tx_push, tx_start, tx_bit_end, tx_idle;
  logic [1:0]       tx_state;
  logic [DIV_W-1:0] tx_div_l, tx_timer;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;

  // The extra pointer bit distinguishes full from empty, so the count reads
  // the full depth rather than wrapping to 0.
  assign tx_cnt     = tx_wp - tx_rp;
  assign tx_full    = (tx_cnt == TX_FULL_CNT);
  assign tx_empty   = (tx_cnt == '0);
  assign tx_push    = wr_acc & (reg_sel == A_DATA) & ~tx_full;
  assign tx_start   = (tx_state == S_IDLE) & ~tx_empty & tx_en;
  assign tx_bit_end = (tx_timer == tx_div_l);
  assign tx_idle    = tx_empty & (tx_state == S_IDLE);

  // NOTE: FIFO storage has no reset; the pointers alone define which entries
  // are valid, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= in_pwdata[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tx_wp <= '0;
    else if (tx_push) tx_wp <= tx_wp + (TAW+1)'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_rp    <= '0;
      tx_div_l <= '0;
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_start) begin
            // Byte leaves the FIFO as the start bit begins; the divisor is
            // frozen for the whole frame.
            tx_state <= S_START;
            tx_shift <= tx_mem[tx_rp[TAW-1:0]];
            tx_rp    <= tx_rp + (TAW+1)'(1);
            tx_div_l <= div_q;
            tx_timer <= '0;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_state <= S_DATA;
            tx_timer <= '0;
            tx_bit   <= '0;
          end else begin
            tx_timer <= tx_timer + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_timer <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) tx_state <= S_STOP;
            else                tx_bit   <= tx_bit + 3'd1;
          end else begin
            tx_timer <= tx_timer + DIV_W'(1);
          end
        end
        default: begin // S_STOP
          if (tx_bit_end) tx_state <= S_IDLE;
          else            tx_timer <= tx_timer + DIV_W'(1);
        end
      endcase
    end
  end

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block can leave it holding a value (inferred latch).
  always_comb begin
    uart_tx = 1'b1;
    if (tx_state == S_START)     uart_tx = 1'b0;
    else if (tx_state == S_DATA) uart_tx = tx_shift[0];
  end

  // --------------------------------------------------------------------------
  // Receiver + RX FIFO
  // --------------------------------------------------------------------------
  logic             rx_line, rx_s1, rx_s2, rx_s3, rx_fall;
  logic [1:0]       rx_state;
  logic [DIV_W-1:0] rx_div_l, rx_timer;
  logic [DIV_W:0]   rx_half, rx_elapsed;
  logic             rx_mid, rx_bit_end, rx_stop_hit;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RAW:0]     rx_wp, rx_rp, rx_cnt;
  logic             rx_full, rx_empty, rx_push, rx_pop, rx_ovr_set, frame_set;

  assign rx_line = loopback ? uart_tx : uart_rx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) {rx_s1, rx_s2, rx_s3} <= 3'b111;
    else        {rx_s1, rx_s2, rx_s3} <= {rx_line, rx_s1, rx_s2};
  end

  assign rx_fall    = rx_s3 & ~rx_s2;
  // The edge detect already costs one clock, so the start-bit check fires
  // after half a bit counted from the synchronised falling edge.
  assign rx_half    = ({1'b0, rx_div_l} + (DIV_W+1)'(1)) >> 1;
  assign rx_elapsed = {1'b0, rx_timer} + (DIV_W+1)'(1);
  assign rx_mid     = (rx_elapsed >= rx_half);
  assign rx_bit_end = (rx_timer == rx_div_l);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= S_IDLE;
      rx_div_l <= '0;
      rx_timer <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (!rx_en) begin
      rx_state <= S_IDLE;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_fall) begin
            rx_state <= S_START;
            rx_div_l <= div_q;
            rx_timer <= '0;
          end
        end
        S_START: begin
          if (rx_mid) begin
            // A line that has gone high again was a glitch, not a start bit.
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
            rx_timer <= '0;
            rx_bit   <= '0;
          end else begin
            rx_timer <= rx_timer + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_timer <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_timer <= rx_timer + DIV_W'(1);
          end
        end
        default: begin // S_STOP
          if (rx_bit_end) rx_state <= S_IDLE;
          else            rx_timer <= rx_timer + DIV_W'(1);
        end
      endcase
    end
  end

  assign rx_cnt      = rx_wp - rx_rp;
  assign rx_full     = (rx_cnt == RX_FULL_CNT);
  assign rx_empty    = (rx_cnt == '0);
  assign rx_stop_hit = rx_en & (rx_state == S_STOP) & rx_bit_end;
  // Full is judged before any same-cycle pop, so a push into a full FIFO is
  // refused even while software is reading.
  assign rx_push     = rx_stop_hit & rx_s2 & ~rx_full;
  assign rx_ovr_set  = rx_stop_hit & rx_s2 & rx_full;
  assign frame_set   = rx_stop_hit & ~rx_s2;
  assign rx_pop      = rd_acc & (reg_sel == A_DATA) & ~rx_empty;

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + (RAW+1)'(1);
      if (rx_pop)  rx_rp <= rx_rp + (RAW+1)'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags, interrupt, read mux
  // --------------------------------------------------------------------------
  logic overrun, frame_err, stat_w1c;

  assign stat_w1c = wr_acc & (reg_sel == A_STAT);

  // A hardware set in the same cycle as a software clear wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      overrun   <= rx_ovr_set | (overrun   & ~(stat_w1c & in_pwdata[4]));
      frame_err <= frame_set  | (frame_err & ~(stat_w1c & in_pwdata[5]));
      irq       <= (ie_rx & ~rx_empty) | (ie_tx_idle & tx_idle) | frame_err | overrun;
    end
  end

  logic [31:0] stat_word;
  assign stat_word = {8'd0, 8'(rx_cnt), 8'(tx_cnt), 2'b00, frame_err, overrun,
                      rx_full, ~rx_empty, tx_idle, tx_full};

  always_comb begin
    in_prdata = '0;
    if (rd_acc) begin
      case (reg_sel)
        A_DATA:  in_prdata = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp[RAW-1:0]]};
        A_STAT:  in_prdata = stat_word;
        A_DIV:   in_prdata = 32'(div_q);
        default: in_prdata = {26'd0, ie_tx_idle, ie_rx, 1'b0, loopback, rx_en, tx_en};
      endcase
    end
  end

  assign in_pslverr = wr_acc & (reg_sel == A_DATA) & tx_full;

`ifdef UART_SIM_PRINT_EN
  always_ff @(posedge clock) begin
    if (tx_push) $write("%c", in_pwdata[7:0]);
  end
`else
  // Console echo compiled out: the serial line is the only output path.
`endif

endmodule

// File: tb/tb_uart_apb_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_apb_fifo -- directed + randomised bench for uart_apb_fifo.
// Expected serial waveforms and FIFO contents come from frame arithmetic
// ({stop, byte, start} sent LSB first, DIV+1 clocks per bit) and byte queues.
// ----------------------------------------------------------------------------
module tb_uart_apb_fifo;

  localparam logic [31:0] R_DATA = 32'h0;
  localparam logic [31:0] R_STAT = 32'h4;
  localparam logic [31:0] R_DIV  = 32'h8;
  localparam logic [31:0] R_CTRL = 32'hC;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]  pprot = 3'd0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = 4'hF;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        uart_rx = 1'b1;
  logic        uart_tx, irq;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  uart_apb_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .in_psel    (psel),
    .in_penable (penable),
    .in_pprot   (pprot),
    .in_paddr   (paddr),
    .in_pwrite  (pwrite),
    .in_pwdata  (pwdata),
    .in_pstrb   (pstrb),
    .in_pready  (pready),
    .in_pslverr (pslverr),
    .in_prdata  (prdata),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer; returns at the falling edge after the commit edge.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    @(negedge clock);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    #1 check("pready_setup", 32'(pready), 32'd0);
    @(negedge clock);
    penable = 1'b1;
    #1;
    rdata = prdata;
    err   = pslverr;
    check("pready_access", 32'(pready), 32'd1);
    @(negedge clock);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] wdata, output logic err);
    logic [31:0] unused_rd;
    apb(1'b1, addr, wdata, unused_rd, err);
  endtask

  task automatic apb_rd(input logic [31:0] addr, output logic [31:0] rdata);
    logic err;
    apb(1'b0, addr, 32'd0, rdata, err);
  endtask

  // Decode one frame from uart_tx, sampling the first clock of every bit.
  task automatic tx_capture(input int p, output logic [7:0] b);
    int n = 0;
    b = '0;
    while (uart_tx !== 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (uart_tx !== 1'b0) begin
      check("tx_start_timeout", 32'(uart_tx), 32'd0);
      return;
    end
    for (int i = 0; i < 8; i++) begin
      repeat (p) @(negedge clock);
      b[i] = uart_tx;
    end
    repeat (p) @(negedge clock);
    check("tx_stop_bit", 32'(uart_tx), 32'd1);
  endtask

  // Drive one frame onto uart_rx, p clocks per bit, then idle high.
  task automatic drive_rx(input logic [7:0] b, input logic stop, input int p);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (p) @(negedge clock);
    end
    uart_rx = 1'b1;
    repeat (p + 6) @(negedge clock);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [7:0]  b, got;
    logic [9:0]  frame;
    logic [7:0]  q[$];
    logic [7:0]  tx_bytes[3];
    int          tx_divs[3];
    int          p, n;

    // ---- reset state ------------------------------------------------------
    repeat (3) @(negedge clock);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("idle_prdata", prdata, 32'd0);
    reset = 1'b1;
    apb_rd(R_STAT, rd); check("rst_stat", rd, 32'h0000_0002);
    apb_rd(R_DIV, rd);  check("rst_div", rd, 32'd16);
    apb_rd(R_CTRL, rd); check("rst_ctrl", rd, 32'h0000_0003);

    // ---- reset in the middle of a frame -----------------------------------
    apb_wr(R_DIV, 32'd3, err);
    apb_wr(R_DATA, 32'h55, err);
    repeat (10) @(negedge clock);
    check("midframe_tx", 32'(uart_tx), 32'd0); // third bit period = data bit 1 of 0x55
    #2 reset = 1'b0;
    #1;
    check("midframe_rst_tx", 32'(uart_tx), 32'd1);
    check("midframe_rst_irq", 32'(irq), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    apb_rd(R_STAT, rd); check("midframe_rst_stat", rd, 32'h0000_0002);
    apb_rd(R_DIV, rd);  check("midframe_rst_div", rd, 32'd16);

    // ---- cycle-exact TX waveforms ----------------------------------------
    tx_bytes[0] = 8'h55;           tx_divs[0] = 3;
    tx_bytes[1] = 8'($urandom);    tx_divs[1] = int'($urandom_range(1, 5));
    tx_bytes[2] = 8'($urandom);    tx_divs[2] = int'($urandom_range(0, 4));
    for (int t = 0; t < 3; t++) begin
      p = tx_divs[t] + 1;
      apb_wr(R_DIV, 32'(tx_divs[t]), err);
      apb_wr(R_DATA, {24'd0, tx_bytes[t]}, err);
      check("tx_push_err", 32'(err), 32'd0);
      check("tx_pre_start", 32'(uart_tx), 32'd1);
      frame = {1'b1, tx_bytes[t], 1'b0};
      for (int k = 1; k <= 10 * p; k++) begin
        @(negedge clock);
        check($sformatf("tx_wave_%0d_clk%0d", t, k), 32'(uart_tx), 32'(frame[(k - 1) / p]));
      end
      @(negedge clock);
      check("tx_after_frame", 32'(uart_tx), 32'd1);
      apb_rd(R_STAT, rd); check("tx_idle_stat", rd, 32'h0000_0002);
    end

    // ---- TX FIFO fill to full, overflow, then drain ------------------------
    apb_wr(R_DIV, 32'd1, err);
    apb_wr(R_CTRL, 32'h2, err);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      apb_wr(R_DATA, {24'd0, b}, err);
      if (i < 16) begin
        q.push_back(b);
        check("txfifo_push_ok", 32'(err), 32'd0);
      end else begin
        check("txfifo_overflow_err", 32'(err), 32'd1);
      end
    end
    apb_rd(R_STAT, rd); check("txfifo_full_stat", rd & 32'h0000_FF03, 32'h0000_1001);
    apb_wr(R_CTRL, 32'h3, err);
    for (int i = 0; i < 16; i++) begin
      tx_capture(2, got);
      check($sformatf("txfifo_order_%0d", i), 32'(got), 32'(q.pop_front()));
    end
    repeat (8) @(negedge clock);
    apb_rd(R_STAT, rd); check("txfifo_drained_stat", rd, 32'h0000_0002);

    // ---- loopback receive with rx interrupt --------------------------------
    apb_wr(R_CTRL, 32'h17, err);
    for (int t = 0; t < 2; t++) begin
      b = (t == 0) ? 8'hA3 : 8'($urandom);
      apb_wr(R_DATA, {24'd0, b}, err);
      n = 0;
      while (irq !== 1'b1 && n < 200) begin
        @(negedge clock);
        n++;
      end
      check("lb_irq_set", 32'(irq), 32'd1);
      apb_rd(R_STAT, rd); check("lb_rx_stat", rd & 32'h00FF_003C, 32'h0001_0004);
      apb_rd(R_DATA, rd); check("lb_rx_data", rd, {24'd0, b});
      apb_rd(R_STAT, rd); check("lb_rx_empty", rd & 32'h00FF_0004, 32'd0);
      repeat (2) @(negedge clock);
      check("lb_irq_clear", 32'(irq), 32'd0);
      repeat (4) @(negedge clock);
    end

    // ---- tx-idle interrupt, one clock of latency ---------------------------
    apb_wr(R_CTRL, 32'h23, err);
    check("txidle_irq_latency", 32'(irq), 32'd0);
    @(negedge clock);
    check("txidle_irq_set", 32'(irq), 32'd1);
    apb_wr(R_CTRL, 32'h03, err);
    @(negedge clock);
    check("txidle_irq_clear", 32'(irq), 32'd0);

    // ---- framing error and W1C --------------------------------------------
    apb_wr(R_DIV, 32'd3, err);
    drive_rx(8'h3C, 1'b0, 4);
    apb_rd(R_STAT, rd); check("frame_err_stat", rd & 32'h00FF_003C, 32'h0000_0020);
    check("frame_err_irq", 32'(irq), 32'd1);
    apb_wr(R_STAT, 32'h20, err);
    apb_rd(R_STAT, rd); check("frame_err_w1c", rd, 32'h0000_0002);
    check("frame_err_irq_clear", 32'(irq), 32'd0);

    // ---- RX overrun: 17 frames, first 16 kept in order ----------------------
    q.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 16) q.push_back(b);
      drive_rx(b, 1'b1, 4);
    end
    apb_rd(R_STAT, rd); check("overrun_stat", rd & 32'h00FF_003C, 32'h0010_001C);
    check("overrun_irq", 32'(irq), 32'd1);
    for (int i = 0; i < 16; i++) begin
      apb_rd(R_DATA, rd);
      check($sformatf("rxfifo_order_%0d", i), rd, {24'd0, q.pop_front()});
    end
    apb(1'b0, R_DATA, 32'd0, rd, err);
    check("rx_empty_read", rd, 32'd0);
    check("rx_empty_pslverr", 32'(err), 32'd0);
    apb_wr(R_STAT, 32'h10, err);
    apb_rd(R_STAT, rd); check("overrun_w1c", rd, 32'h0000_0002);
    check("overrun_irq_clear", 32'(irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
